// File: rtl/ps2_pkg.sv
// ps2_pkg: scan-code constants and decoder FSM state encoding
package ps2_pkg;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_PAUSE = 8'hE1;
    localparam logic [7:0] SC_BAT   = 8'hAA;
    localparam logic [7:0] SC_ERR0  = 8'h00;
    localparam logic [7:0] SC_ERR1  = 8'hFF;
    typedef enum logic [1:0] {IDLE, POP, WAIT} state_t;
endpackage

// File: rtl/ps2_ascii_lut.sv
// ps2_ascii_lut: set-2 make code to ASCII (letters lower-case, digits, space, enter), 0 if unmapped
module ps2_ascii_lut (
    input  logic [7:0] code_i,
    output logic [7:0] ascii_o
);
    // pure lookup table
    always_comb begin
        ascii_o = 8'h00;
        case (code_i)
            8'h1C: ascii_o = "a"; 8'h32: ascii_o = "b"; 8'h21: ascii_o = "c"; 8'h23: ascii_o = "d";
            8'h24: ascii_o = "e"; 8'h2B: ascii_o = "f"; 8'h34: ascii_o = "g"; 8'h33: ascii_o = "h";
            8'h43: ascii_o = "i"; 8'h3B: ascii_o = "j"; 8'h42: ascii_o = "k"; 8'h4B: ascii_o = "l";
            8'h3A: ascii_o = "m"; 8'h31: ascii_o = "n"; 8'h44: ascii_o = "o"; 8'h4D: ascii_o = "p";
            8'h15: ascii_o = "q"; 8'h2D: ascii_o = "r"; 8'h1B: ascii_o = "s"; 8'h2C: ascii_o = "t";
            8'h3C: ascii_o = "u"; 8'h2A: ascii_o = "v"; 8'h1D: ascii_o = "w"; 8'h22: ascii_o = "x";
            8'h35: ascii_o = "y"; 8'h1A: ascii_o = "z";
            8'h45: ascii_o = "0"; 8'h16: ascii_o = "1"; 8'h1E: ascii_o = "2"; 8'h26: ascii_o = "3";
            8'h25: ascii_o = "4"; 8'h2E: ascii_o = "5"; 8'h36: ascii_o = "6"; 8'h3D: ascii_o = "7";
            8'h3E: ascii_o = "8"; 8'h46: ascii_o = "9";
            8'h29: ascii_o = 8'h20;
            8'h5A: ascii_o = 8'h0D;
            default: ascii_o = 8'h00;
        endcase
    end
endmodule

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: pops PS/2 FIFO bytes, resolves E0/F0/E1 prefixes, emits key events (ASCII via PS2_ASCII_EN)
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int E1_SKIP = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       ps2_data,
    input  logic             ps2_ready,
    input  logic             fifo_overflow,
    output logic             nextdata_n,
    output logic             key_valid,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_break,
    output logic             key_repeat,
    output logic [7:0]       key_ascii,
    output logic             key_held,
    output logic [CNT_W-1:0] press_count,
    output logic             err_overflow
);
    localparam int SKIP_W = (E1_SKIP > 0) ? $clog2(E1_SKIP + 1) : 1;

    state_t             state_q, state_d;
    logic [7:0]         byte_q, byte_d, code_q, code_d, held_code_q, held_code_d;
    logic [SKIP_W-1:0]  skip_q, skip_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               nd_q, nd_d, valid_q, valid_d, kext_q, kext_d, kbrk_q, kbrk_d;
    logic               rep_q, rep_d, held_q, held_d, held_ext_q, held_ext_d;
    logic               ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d, err_q, err_d;
    logic               same_key;

    // byte under decode names the key currently held (same code, same E0 qualifier)
    assign same_key = held_q && held_code_q == byte_q && held_ext_q == ext_pend_q;

    // pop handshake sequencing and scan-code decode
    always_comb begin
        state_d    = state_q;
        byte_d     = byte_q;
        nd_d       = 1'b1;
        valid_d    = 1'b0;
        code_d     = code_q;
        kext_d     = kext_q;
        kbrk_d     = kbrk_q;
        rep_d      = rep_q;
        held_d     = held_q;
        held_code_d = held_code_q;
        held_ext_d = held_ext_q;
        cnt_d      = cnt_q;
        skip_d     = skip_q;
        ext_pend_d = ext_pend_q;
        brk_pend_d = brk_pend_q;
        err_d      = err_q | fifo_overflow;
        case (state_q)
            IDLE: if (ps2_ready) begin
                byte_d  = ps2_data;
                nd_d    = 1'b0;
                state_d = POP;
            end
            POP: state_d = WAIT;
            WAIT: begin
                state_d = IDLE;
                if (skip_q != '0) skip_d = skip_q - SKIP_W'(1);
                else if (byte_q == SC_PAUSE) begin
                    skip_d     = SKIP_W'(E1_SKIP);
                    ext_pend_d = 1'b0;
                    brk_pend_d = 1'b0;
                end
                else if (byte_q == SC_EXT) ext_pend_d = 1'b1;
                else if (byte_q == SC_BREAK) brk_pend_d = 1'b1;
                else if (byte_q == SC_BAT || byte_q == SC_ERR0 || byte_q == SC_ERR1) begin
                    ext_pend_d = 1'b0;
                    brk_pend_d = 1'b0;
                end
                else begin
                    valid_d    = 1'b1;
                    code_d     = byte_q;
                    kext_d     = ext_pend_q;
                    kbrk_d     = brk_pend_q;
                    ext_pend_d = 1'b0;
                    brk_pend_d = 1'b0;
                    rep_d      = !brk_pend_q && same_key;
                    if (brk_pend_q) held_d = same_key ? 1'b0 : held_q;
                    else if (!same_key) begin
                        held_d      = 1'b1;
                        held_code_d = byte_q;
                        held_ext_d  = ext_pend_q;
                        cnt_d       = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            byte_q      <= '0;
            nd_q        <= 1'b1;
            valid_q     <= 1'b0;
            code_q      <= '0;
            kext_q      <= 1'b0;
            kbrk_q      <= 1'b0;
            rep_q       <= 1'b0;
            held_q      <= 1'b0;
            held_code_q <= '0;
            held_ext_q  <= 1'b0;
            cnt_q       <= '0;
            skip_q      <= '0;
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_q      <= byte_d;
            nd_q        <= nd_d;
            valid_q     <= valid_d;
            code_q      <= code_d;
            kext_q      <= kext_d;
            kbrk_q      <= kbrk_d;
            rep_q       <= rep_d;
            held_q      <= held_d;
            held_code_q <= held_code_d;
            held_ext_q  <= held_ext_d;
            cnt_q       <= cnt_d;
            skip_q      <= skip_d;
            ext_pend_q  <= ext_pend_d;
            brk_pend_q  <= brk_pend_d;
            err_q       <= err_d;
        end
    end

    assign nextdata_n   = nd_q;
    assign key_valid    = valid_q;
    assign key_code     = code_q;
    assign key_ext      = kext_q;
    assign key_break    = kbrk_q;
    assign key_repeat   = rep_q;
    assign key_held     = held_q;
    assign press_count  = cnt_q;
    assign err_overflow = err_q;

`ifdef PS2_ASCII_EN
    logic [7:0] lut_ascii;
    ps2_ascii_lut u_lut (.code_i(code_q), .ascii_o(lut_ascii));
    assign key_ascii = kext_q ? 8'h00 : lut_ascii;
`else
    assign key_ascii = 8'h00;
`endif
endmodule
